// File: rtl/fifo_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fifo_ctrl_pkg
// Description : Shared types and constants for the FIFO control block.
// Revision    : 1.0 - initial release
// ============================================================================
package fifo_ctrl_pkg;

    typedef logic bit_t;

    localparam int FIFO_DEPTH = 16;
    localparam int FIFO_AW    = $clog2(FIFO_DEPTH);

    typedef logic [FIFO_AW-1:0] RAM_size;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        PARTIAL = 2'd1,
        FULL    = 2'd2
    } fifo_state_t;

endpackage
`default_nettype wire

// File: rtl/fifo_ctrl_wrap_counter.sv
`default_nettype none
// ============================================================================
// Module      : wrap_counter
// Description : AW-bit pointer with increment enable; wraps naturally at 2**AW.
// Revision    : 1.0 - initial release
// ============================================================================
module wrap_counter #(
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          inc,
    output logic [AW-1:0] value
);

    logic [AW-1:0] r_value;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_value <= '0;
        end else if (inc) begin
            r_value <= r_value + AW'(1);
        end
    end

    assign value = r_value;

endmodule
`default_nettype wire

// File: rtl/fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fifo_ctrl
// Description : FIFO RAM controller - pointers, occupancy, status and flags.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_ctrl
    import fifo_ctrl_pkg::*;
#(
    parameter int DEPTH     = FIFO_DEPTH,
    parameter int AW        = $clog2(DEPTH),
    parameter int AF_THRESH = DEPTH - 4,
    parameter int AE_THRESH = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    output logic [AW-1:0] w_add,
    output logic          w_en,
    output logic [AW-1:0] r_add,
    output logic          r_en,
    output logic          rd_valid,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty,
    output logic          almost_full,
    output logic          almost_empty,
    output logic          overflow,
    output logic          underflow
);

    localparam logic [AW:0] c_depth_m1 = (AW+1)'(DEPTH - 1);
    localparam logic [AW:0] c_one      = (AW+1)'(1);
    localparam logic [AW:0] c_af       = (AW+1)'(AF_THRESH);
    localparam logic [AW:0] c_ae       = (AW+1)'(AE_THRESH);

    fifo_state_t r_state;
    logic [AW:0] r_count;
    logic        r_rd_valid;
    logic        r_overflow;
    logic        r_underflow;
    bit_t        w_push_ok;
    bit_t        w_pop_ok;

    // Acceptance looks only at registered state: no empty bypass, no full pass-through.
    assign w_push_ok = push && (r_state != FULL);
    assign w_pop_ok  = pop  && (r_state != EMPTY);

    wrap_counter #(.AW(AW)) u_w_ptr (
        .clk   (clk),
        .reset (reset),
        .inc   (w_push_ok),
        .value (w_add)
    );

    wrap_counter #(.AW(AW)) u_r_ptr (
        .clk   (clk),
        .reset (reset),
        .inc   (w_pop_ok),
        .value (r_add)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= EMPTY;
            r_count     <= '0;
            r_rd_valid  <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_rd_valid  <= w_pop_ok;
            r_overflow  <= push && (r_state == FULL);
            r_underflow <= pop  && (r_state == EMPTY);

            if (w_push_ok && !w_pop_ok) begin
                r_count <= r_count + c_one;
            end else if (w_pop_ok && !w_push_ok) begin
                r_count <= r_count - c_one;
            end

            case (r_state)
                EMPTY: begin
                    if (w_push_ok) r_state <= PARTIAL;
                end
                PARTIAL: begin
                    if (w_push_ok && !w_pop_ok && r_count == c_depth_m1) begin
                        r_state <= FULL;
                    end else if (w_pop_ok && !w_push_ok && r_count == c_one) begin
                        r_state <= EMPTY;
                    end
                end
                FULL: begin
                    if (w_pop_ok) r_state <= PARTIAL;
                end
                default: r_state <= EMPTY;
            endcase
        end
    end

    assign w_en         = w_push_ok;
    assign r_en         = w_pop_ok;
    assign rd_valid     = r_rd_valid;
    assign count        = r_count;
    assign full         = (r_state == FULL);
    assign empty        = (r_state == EMPTY);
    assign almost_full  = (r_count >= c_af);
    assign almost_empty = (r_count <= c_ae);
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_ctrl
// Description : Directed self-checking bench for fifo_ctrl (DEPTH = 16).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_ctrl;

    logic       clk;
    logic       reset;
    logic       push;
    logic       pop;
    logic [3:0] w_add;
    logic       w_en;
    logic [3:0] r_add;
    logic       r_en;
    logic       rd_valid;
    logic [4:0] count;
    logic       full;
    logic       empty;
    logic       almost_full;
    logic       almost_empty;
    logic       overflow;
    logic       underflow;

    int n_total;
    int n_passed;

    fifo_ctrl u_dut (
        .clk          (clk),
        .reset        (reset),
        .push         (push),
        .pop          (pop),
        .w_add        (w_add),
        .w_en         (w_en),
        .r_add        (r_add),
        .r_en         (r_en),
        .rd_valid     (rd_valid),
        .count        (count),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       psh;
        logic       pp;
        logic [3:0] wa;
        logic [3:0] ra;
        logic       we;
        logic       re;
        logic       rv;
        logic [4:0] cnt;
        logic       fu;
        logic       em;
        logic       af;
        logic       ae;
        logic       ov;
        logic       un;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Drive inputs on the falling edge; outputs are sampled 1ns later, mid-cycle.
    task automatic apply(input logic r, input logic p, input logic q);
        @(negedge clk);
        reset = r;
        push  = p;
        pop   = q;
        #1;
    endtask

    task automatic chk_vec(input int idx, input vec_t v);
        string s;
        s = $sformatf("vec%0d", idx);
        chk({s, ".w_add"}, w_add, v.wa);
        chk({s, ".r_add"}, r_add, v.ra);
        chk({s, ".w_en"}, w_en, v.we);
        chk({s, ".r_en"}, r_en, v.re);
        chk({s, ".rd_valid"}, rd_valid, v.rv);
        chk({s, ".count"}, count, v.cnt);
        chk({s, ".full"}, full, v.fu);
        chk({s, ".empty"}, empty, v.em);
        chk({s, ".almost_full"}, almost_full, v.af);
        chk({s, ".almost_empty"}, almost_empty, v.ae);
        chk({s, ".overflow"}, overflow, v.ov);
        chk({s, ".underflow"}, underflow, v.un);
    endtask

    initial begin
        n_total  = 0;
        n_passed = 0;
        reset = 1'b1;
        push  = 1'b0;
        pop   = 1'b0;

        //            rst   psh   pp    wa    ra    we    re    rv    cnt   fu    em    af    ae    ov    un
        vecs[0] = '{1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[5] = '{1'b0, 1'b1, 1'b1, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[6] = '{1'b0, 1'b0, 1'b0, 4'd1, 4'd0, 1'b0, 1'b0, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[7] = '{1'b0, 1'b0, 1'b1, 4'd1, 4'd0, 1'b0, 1'b1, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[8] = '{1'b0, 1'b0, 1'b0, 4'd1, 4'd1, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[9] = '{1'b0, 1'b0, 1'b0, 4'd1, 4'd1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};

        repeat (2) @(posedge clk);

        // Reset/idle, pop on empty, push+pop on empty, single push/pop round trip.
        for (int i = 0; i < 10; i++) begin
            apply(vecs[i].rst, vecs[i].psh, vecs[i].pp);
            chk_vec(i, vecs[i]);
        end

        // Fill from reset.
        apply(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) begin
            apply(1'b0, 1'b1, 1'b0);
            chk($sformatf("fill%0d.w_add", i), w_add, i);
            chk($sformatf("fill%0d.w_en", i), w_en, 1);
            chk($sformatf("fill%0d.count", i), count, i);
            chk($sformatf("fill%0d.full", i), full, 0);
            chk($sformatf("fill%0d.empty", i), empty, (i == 0) ? 1 : 0);
            chk($sformatf("fill%0d.almost_full", i), almost_full, (i >= 12) ? 1 : 0);
            chk($sformatf("fill%0d.almost_empty", i), almost_empty, (i <= 4) ? 1 : 0);
        end
        apply(1'b0, 1'b1, 1'b0);
        chk("push_full.w_en", w_en, 0);
        chk("push_full.count", count, 16);
        chk("push_full.full", full, 1);
        chk("push_full.almost_full", almost_full, 1);
        apply(1'b0, 1'b0, 1'b0);
        chk("ovf_pulse.overflow", overflow, 1);
        chk("ovf_pulse.count", count, 16);
        chk("ovf_pulse.w_add", w_add, 0);
        apply(1'b0, 1'b0, 1'b0);
        chk("ovf_clear.overflow", overflow, 0);

        // Drain from full.
        for (int i = 0; i < 16; i++) begin
            apply(1'b0, 1'b0, 1'b1);
            chk($sformatf("drain%0d.r_add", i), r_add, i);
            chk($sformatf("drain%0d.r_en", i), r_en, 1);
            chk($sformatf("drain%0d.count", i), count, 16 - i);
            chk($sformatf("drain%0d.rd_valid", i), rd_valid, (i > 0) ? 1 : 0);
            chk($sformatf("drain%0d.full", i), full, (i == 0) ? 1 : 0);
        end
        apply(1'b0, 1'b0, 1'b0);
        chk("drained.empty", empty, 1);
        chk("drained.count", count, 0);
        chk("drained.rd_valid", rd_valid, 1);
        apply(1'b0, 1'b0, 1'b1);
        chk("pop_empty.r_en", r_en, 0);
        apply(1'b0, 1'b0, 1'b0);
        chk("udf_pulse.underflow", underflow, 1);
        chk("udf_pulse.rd_valid", rd_valid, 0);
        apply(1'b0, 1'b0, 1'b0);
        chk("udf_clear.underflow", underflow, 0);

        // Refill, then push+pop while full.
        for (int i = 0; i < 16; i++) begin
            apply(1'b0, 1'b1, 1'b0);
            chk($sformatf("refill%0d.w_en", i), w_en, 1);
        end
        apply(1'b0, 1'b1, 1'b1);
        chk("full_pp.r_en", r_en, 1);
        chk("full_pp.w_en", w_en, 0);
        chk("full_pp.count", count, 16);
        apply(1'b0, 1'b0, 1'b0);
        chk("full_pp_after.overflow", overflow, 1);
        chk("full_pp_after.underflow", underflow, 0);
        chk("full_pp_after.count", count, 15);
        chk("full_pp_after.full", full, 0);
        chk("full_pp_after.rd_valid", rd_valid, 1);
        chk("full_pp_after.r_add", r_add, 1);
        chk("full_pp_after.w_add", w_add, 0);

        // Pop down to 5, then steady push+pop across the pointer wrap.
        for (int i = 0; i < 10; i++) begin
            apply(1'b0, 1'b0, 1'b1);
            chk($sformatf("popdown%0d.r_en", i), r_en, 1);
        end
        apply(1'b0, 1'b0, 1'b0);
        chk("at5.count", count, 5);
        chk("at5.r_add", r_add, 11);
        chk("at5.w_add", w_add, 0);
        for (int i = 0; i < 20; i++) begin
            apply(1'b0, 1'b1, 1'b1);
            chk($sformatf("steady%0d.count", i), count, 5);
            chk($sformatf("steady%0d.w_add", i), w_add, i % 16);
            chk($sformatf("steady%0d.r_add", i), r_add, (11 + i) % 16);
            chk($sformatf("steady%0d.w_en", i), w_en, 1);
            chk($sformatf("steady%0d.r_en", i), r_en, 1);
            chk($sformatf("steady%0d.overflow", i), overflow, 0);
            chk($sformatf("steady%0d.underflow", i), underflow, 0);
        end
        apply(1'b0, 1'b0, 1'b0);
        chk("steady_end.count", count, 5);
        chk("steady_end.w_add", w_add, 4);
        chk("steady_end.r_add", r_add, 15);

        // Reset with a simultaneous push at count 9.
        for (int i = 0; i < 4; i++) apply(1'b0, 1'b1, 1'b0);
        apply(1'b0, 1'b0, 1'b0);
        chk("at9.count", count, 9);
        apply(1'b1, 1'b1, 1'b0);
        chk("rst_push.count", count, 9);
        apply(1'b0, 1'b0, 1'b0);
        chk("post_rst.count", count, 0);
        chk("post_rst.w_add", w_add, 0);
        chk("post_rst.r_add", r_add, 0);
        chk("post_rst.empty", empty, 1);
        chk("post_rst.almost_empty", almost_empty, 1);
        chk("post_rst.overflow", overflow, 0);
        chk("post_rst.rd_valid", rd_valid, 0);

        $display("%0d/%0d checks passed", n_passed, n_total);
        $finish;
    end

endmodule
`default_nettype wire
